// File: rtl/regfile_write_arbiter.sv
// -----------------------------------------------------------------------------
// regfile_write_arbiter
//
// Shares the single register-file write port between NREQ requesters using a
// round-robin arbiter with valid/ready handshakes. The winning request is
// captured into a registered wrtEn/wrtInd/dIn triple that feeds the register
// file directly, so a transfer in cycle N writes the register file at the end
// of cycle N+1.
//
// Optional feature (macro REGFILE_CLEAR_EN): after reset an INIT state walks
// every index and writes 0 before any request is granted; busy is high while
// this clearing runs. Without the macro, grants start the first cycle after
// reset and busy is tied low.
//
// Parameters:
//   DBITS    data bits per register
//   ABITS    register index bits (WORDS = 1 << ABITS)
//   NREQ     number of requesters, 2..4
//   ZERO_REG when 1, accepted writes to index 0 are acknowledged but dropped
//
// Ports:
//   clk       clock, rising edge
//   reset     synchronous active-high reset
//   reqValid  per-requester write request
//   reqReady  per-requester grant, one-hot or zero (combinational)
//   reqInd    packed target indices, requester i at [i*ABITS +: ABITS]
//   reqData   packed write data, requester i at [i*DBITS +: DBITS]
//   wrtEn     register-file write enable (registered)
//   wrtInd    register-file write index (registered)
//   dIn       register-file write data (registered)
//   busy      high while clearing is in progress
//   grantId   index of the most recently accepted requester (registered)
// -----------------------------------------------------------------------------
module regfile_write_arbiter #(
  parameter int DBITS    = 32,
  parameter int ABITS    = 4,
  parameter int NREQ     = 3,
  parameter int ZERO_REG = 1
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [NREQ-1:0]        reqValid,
  output logic [NREQ-1:0]        reqReady,
  input  logic [NREQ*ABITS-1:0]  reqInd,
  input  logic [NREQ*DBITS-1:0]  reqData,
  output logic                   wrtEn,
  output logic [ABITS-1:0]       wrtInd,
  output logic [DBITS-1:0]       dIn,
  output logic                   busy,
  output logic [1:0]             grantId
);

  logic             r_wrt_en;
  logic [ABITS-1:0] r_wrt_ind;
  logic [DBITS-1:0] r_din;
  logic [1:0]       r_grant_id;
  logic [1:0]       r_ptr;

  logic             w_run;
  logic             w_found;
  logic [NREQ-1:0]  w_grant_oh;
  logic [1:0]       w_grant_idx;
  logic [1:0]       w_next_ptr;
  logic             w_xfer;
  logic             w_drop;
  logic [ABITS-1:0] w_sel_ind;
  logic [DBITS-1:0] w_sel_data;
  int               w_idx;

`ifdef REGFILE_CLEAR_EN
  typedef enum logic {ST_INIT, ST_RUN} state_t;

  localparam logic [ABITS-1:0] LAST_IDX = {ABITS{1'b1}};

  state_t           r_state;
  state_t           w_state_next;
  logic [ABITS-1:0] r_cnt;

  always_ff @(posedge clk) begin
    if (reset) r_state <= ST_INIT;
    else       r_state <= w_state_next;
  end

  // Leave INIT on the edge that writes the last index.
  always_comb begin
    w_state_next = r_state;
    if (r_state == ST_INIT && r_cnt == LAST_IDX) w_state_next = ST_RUN;
  end

  assign w_run = (r_state == ST_RUN);
  assign busy  = (r_state == ST_INIT);
`else
  assign w_run = 1'b1;
  assign busy  = 1'b0;
`endif

  // Round-robin search starting at r_ptr; the first valid requester wins.
  // NOTE: every variable written here gets a default first, otherwise
  // synthesis infers latches for the paths that do not assign it.
  always_comb begin
    w_found     = 1'b0;
    w_grant_oh  = '0;
    w_grant_idx = '0;
    w_idx       = 0;
    for (int k = 0; k < NREQ; k++) begin
      w_idx = (int'(r_ptr) + k) % NREQ;
      if (!w_found && reqValid[w_idx]) begin
        w_found             = 1'b1;
        w_grant_oh[w_idx]   = 1'b1;
        w_grant_idx         = 2'(w_idx);
      end
    end
  end

  assign reqReady   = w_run ? w_grant_oh : '0;
  assign w_xfer     = w_run & w_found;
  assign w_sel_ind  = reqInd[int'(w_grant_idx)*ABITS +: ABITS];
  assign w_sel_data = reqData[int'(w_grant_idx)*DBITS +: DBITS];
  assign w_next_ptr = (w_grant_idx == 2'(NREQ-1)) ? 2'd0 : w_grant_idx + 2'd1;
  // A write to register 0 is acknowledged but never reaches the register file.
  assign w_drop     = (ZERO_REG != 0) && (w_sel_ind == '0);

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values, independent of statement order.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_wrt_en   <= 1'b0;
      r_wrt_ind  <= '0;
      r_din      <= '0;
      r_grant_id <= '0;
      r_ptr      <= '0;
`ifdef REGFILE_CLEAR_EN
      r_cnt      <= '0;
    end else if (r_state == ST_INIT) begin
      r_wrt_en  <= 1'b1;
      r_wrt_ind <= r_cnt;
      r_din     <= '0;
      r_cnt     <= r_cnt + 1'b1;
`endif
    end else if (w_xfer) begin
      r_wrt_en   <= !w_drop;
      r_wrt_ind  <= w_sel_ind;
      r_din      <= w_sel_data;
      r_grant_id <= w_grant_idx;
      r_ptr      <= w_next_ptr;
    end else begin
      r_wrt_en <= 1'b0;
    end
  end

  assign wrtEn   = r_wrt_en;
  assign wrtInd  = r_wrt_ind;
  assign dIn     = r_din;
  assign grantId = r_grant_id;

endmodule

// File: tb/tb_regfile_write_arbiter.sv
// -----------------------------------------------------------------------------
// tb_regfile_write_arbiter
//
// Directed steps followed by randomized traffic, all compared against a
// behavioural model of the arbiter: the model tracks how many clearing writes
// remain, the priority pointer as an integer, and the last write that should
// have reached the register file. Works with or without REGFILE_CLEAR_EN.
// -----------------------------------------------------------------------------
module tb_regfile_write_arbiter;

  localparam int DBITS    = 32;
  localparam int ABITS    = 4;
  localparam int NREQ     = 3;
  localparam int ZERO_REG = 1;
  localparam int WORDS    = 1 << ABITS;
`ifdef REGFILE_CLEAR_EN
  localparam int CLR = 1;
`else
  localparam int CLR = 0;
`endif

  logic                  clk = 1'b0;
  logic                  reset;
  logic [NREQ-1:0]       reqValid;
  logic [NREQ-1:0]       reqReady;
  logic [NREQ*ABITS-1:0] reqInd;
  logic [NREQ*DBITS-1:0] reqData;
  logic                  wrtEn;
  logic [ABITS-1:0]      wrtInd;
  logic [DBITS-1:0]      dIn;
  logic                  busy;
  logic [1:0]            grantId;

  regfile_write_arbiter #(
    .DBITS(DBITS), .ABITS(ABITS), .NREQ(NREQ), .ZERO_REG(ZERO_REG)
  ) dut (
    .clk(clk), .reset(reset), .reqValid(reqValid), .reqReady(reqReady),
    .reqInd(reqInd), .reqData(reqData), .wrtEn(wrtEn), .wrtInd(wrtInd),
    .dIn(dIn), .busy(busy), .grantId(grantId)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;

  // Stimulus per requester.
  logic [ABITS-1:0] v_ind  [NREQ];
  logic [DBITS-1:0] v_data [NREQ];

  // Reference model state.
  int               m_clr_left;
  int               m_ptr;
  bit               m_wen;
  int               m_ind;
  logic [DBITS-1:0] m_data;
  int               m_gid;
  bit               m_ind_known;
  logic [NREQ-1:0]  last_rdy;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_clr_left  = CLR ? WORDS : 0;
    m_ptr       = 0;
    m_wen       = 1'b0;
    m_ind       = 0;
    m_data      = '0;
    m_gid       = 0;
    m_ind_known = 1'b1;
  endtask

  // One clock cycle: apply inputs, check combinational grant mid-cycle,
  // advance the model across the edge and check the registered outputs.
  task automatic cycle(input logic rst, input logic [NREQ-1:0] val);
    bit              in_init;
    int              g;
    logic [NREQ-1:0] exp_rdy;
    reset    = rst;
    reqValid = val;
    for (int i = 0; i < NREQ; i++) begin
      reqInd[i*ABITS +: ABITS] = v_ind[i];
      reqData[i*DBITS +: DBITS] = v_data[i];
    end
    #4;
    in_init = (m_clr_left > 0);
    exp_rdy = '0;
    g       = -1;
    if (!in_init) begin
      for (int k = 0; k < NREQ; k++) begin
        int idx;
        idx = (m_ptr + k) % NREQ;
        if (g < 0 && val[idx]) begin
          g            = idx;
          exp_rdy[idx] = 1'b1;
        end
      end
    end
    check("reqReady", 64'(reqReady), 64'(exp_rdy));
    check("busy", 64'(busy), 64'(in_init));
    last_rdy = rst ? '0 : exp_rdy;
    @(posedge clk);
    #1;
    if (rst) begin
      model_reset();
    end else if (in_init) begin
      m_wen  = 1'b1;
      m_ind  = WORDS - m_clr_left;
      m_data = '0;
      m_clr_left--;
      m_ind_known = 1'b1;
    end else if (g >= 0) begin
      m_gid = g;
      m_ptr = (g + 1) % NREQ;
      if (ZERO_REG != 0 && v_ind[g] == 0) begin
        m_wen       = 1'b0;
        m_ind_known = 1'b0;
      end else begin
        m_wen       = 1'b1;
        m_ind       = int'(v_ind[g]);
        m_data      = v_data[g];
        m_ind_known = 1'b1;
      end
    end else begin
      m_wen = 1'b0;
    end
    check("wrtEn", 64'(wrtEn), 64'(m_wen));
    check("grantId", 64'(grantId), 64'(m_gid));
    if (m_ind_known) begin
      check("wrtInd", 64'(wrtInd), 64'(m_ind));
      check("dIn", 64'(dIn), 64'(m_data));
    end
  endtask

  task automatic do_reset();
    cycle(1'b1, '0);
    cycle(1'b1, '0);
    // Clearing takes WORDS cycles with every requester asking; none granted.
    for (int c = 0; c < CLR * WORDS; c++) cycle(1'b0, '1);
  endtask

  logic [NREQ-1:0] r_val;
  logic [NREQ-1:0] pend;

  initial begin
    for (int i = 0; i < NREQ; i++) begin
      v_ind[i]  = ABITS'(i + 1);
      v_data[i] = 32'hA000_0000 + DBITS'(i);
    end
    reset    = 1'b1;
    reqValid = '0;
    reqInd   = '0;
    reqData  = '0;
    last_rdy = '0;
    model_reset();
    @(posedge clk);
    #1;

    // Reset state plus clear sequence (when compiled in).
    do_reset();

    // Round robin from ptr=0: expected grants 0,1,2,0,1.
    for (int c = 0; c < 5; c++) begin
      for (int i = 0; i < NREQ; i++) begin
        v_ind[i]  = ABITS'(4 + i);
        v_data[i] = 32'h1000_0000 * DBITS'(i + 1) + DBITS'(c);
      end
      cycle(1'b0, '1);
    end

    // Single request from requester 1.
    v_ind[1]  = 4'd5;
    v_data[1] = 32'hDEAD_BEEF;
    cycle(1'b0, 3'b010);
    cycle(1'b0, 3'b000);

    // Stall/hold: requester 2 waits two cycles behind 0 and 1 with ptr=0.
    do_reset();
    v_ind[2]  = 4'd9;
    v_data[2] = 32'hCAFE_0002;
    for (int c = 0; c < 3; c++) begin
      v_ind[0]  = ABITS'(c + 1);
      v_data[0] = 32'h0000_0100 + DBITS'(c);
      v_ind[1]  = ABITS'(c + 10);
      v_data[1] = 32'h0000_0200 + DBITS'(c);
      cycle(1'b0, '1);
    end

    // Zero-register drop: acknowledged, no write, ptr moves to 1.
    v_ind[0]  = '0;
    v_data[0] = 32'h0000_1234;
    cycle(1'b0, 3'b001);
    v_ind[0] = 4'd3;
    cycle(1'b0, '1);

`ifdef REGFILE_CLEAR_EN
    // Reset in the middle of clearing restarts at index 0.
    cycle(1'b1, '0);
    for (int c = 0; c < 7; c++) cycle(1'b0, '0);
    cycle(1'b1, '1);
    for (int c = 0; c < WORDS; c++) cycle(1'b0, '0);
`endif

    // Randomized traffic; pending requests keep index and data stable.
    pend = '0;
    for (int c = 0; c < 400; c++) begin
      for (int i = 0; i < NREQ; i++) begin
        if (pend[i]) begin
          r_val[i] = 1'b1;
        end else begin
          r_val[i]  = ($urandom_range(0, 99) < 60);
          v_ind[i]  = ABITS'($urandom);
          v_data[i] = DBITS'($urandom);
        end
      end
      cycle((c % 97) == 96, r_val);
      pend = r_val & ~last_rdy;
      if ((c % 97) == 96) pend = '0;
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
